// File: rtl/raster_tile_walker.sv
// raster_tile_walker: depth-first quadrant walk of one tile per primitive, emitting overlapping blocks.
// Define RASTER_WALKER_STATS_EN to add the perf_tested/perf_culled/perf_emitted counters.
`ifndef RASTER_DIM_BITS
`define RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 24
`endif

module raster_tile_walker #(
  parameter int TILE_LOGSIZE  = 5,
  parameter int BLOCK_LOGSIZE = 2,
  parameter int PID_WIDTH     = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   valid_in,
  output logic                                   ready_in,
  input  logic [`RASTER_DIM_BITS-1:0]            xloc_in,
  input  logic [`RASTER_DIM_BITS-1:0]            yloc_in,
  input  logic [2:0][2:0][`RASTER_DATA_BITS-1:0] edges_in,
  input  logic [PID_WIDTH-1:0]                   pid_in,
  output logic                                   valid_out,
  input  logic                                   ready_out,
  output logic [`RASTER_DIM_BITS-1:0]            xloc_out,
  output logic [`RASTER_DIM_BITS-1:0]            yloc_out,
  output logic [2:0][2:0][`RASTER_DATA_BITS-1:0] edges_out,
  output logic [PID_WIDTH-1:0]                   pid_out,
  output logic                                   busy
`ifdef RASTER_WALKER_STATS_EN
  ,
  output logic [31:0]                            perf_tested,
  output logic [31:0]                            perf_culled,
  output logic [31:0]                            perf_emitted
`endif
);

  localparam int DIM   = `RASTER_DIM_BITS;
  localparam int DW    = `RASTER_DATA_BITS;
  localparam int DEPTH = 3 * (TILE_LOGSIZE - BLOCK_LOGSIZE) + 1;
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int LVW   = $clog2(TILE_LOGSIZE + 1);
  localparam logic [LVW-1:0] LVL_TILE = LVW'(TILE_LOGSIZE);
  localparam logic [LVW-1:0] LVL_BLK  = LVW'(BLOCK_LOGSIZE);

  typedef struct packed {
    logic [LVW-1:0]       lvl;
    logic [DIM-1:0]       x;
    logic [DIM-1:0]       y;
    logic [2:0][DW-1:0]   c;
  } entry_t;

  typedef enum logic {S_IDLE, S_WALK} state_t;

  state_t                  state_q, state_d;
  entry_t [DEPTH-1:0]      stk_q, stk_d;
  logic   [SPW-1:0]        sp_q, sp_d;
  logic                    ov_q, ov_d;
  logic   [DIM-1:0]        ox_q, ox_d, oy_q, oy_d;
  logic   [2:0][DW-1:0]    oc_q, oc_d;
  logic   [2:0][DW-1:0]    a_q, b_q;
  logic   [PID_WIDTH-1:0]  pid_q;
  logic                    accept;
  logic                    drain;
  logic                    hit;
  entry_t                  top;

  function automatic entry_t child(input entry_t p, input logic dx, input logic dy,
                                   input logic [2:0][DW-1:0] a, input logic [2:0][DW-1:0] b);
    entry_t         ch;
    logic [LVW-1:0] lm1;
    logic [DIM-1:0] h;
    lm1    = p.lvl - LVW'(1);
    h      = DIM'(1) << lm1;
    ch.lvl = lm1;
    ch.x   = dx ? p.x + h : p.x;
    ch.y   = dy ? p.y + h : p.y;
    for (int i = 0; i < 3; i++) begin
      ch.c[i] = p.c[i];
      if (dx) ch.c[i] = ch.c[i] + (a[i] << lm1);
      if (dy) ch.c[i] = ch.c[i] + (b[i] << lm1);
    end
    return ch;
  endfunction

  always_comb begin
    top = '0;
    for (int k = 0; k < DEPTH; k++)
      if (k == int'(sp_q) - 1) top = stk_q[k];
  end

  // Max edge value over the square is c plus the non-negative gradients times the size.
  always_comb begin
    logic [DW-1:0] ext;
    logic [DW-1:0] sum;
    hit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ext = '0;
      if (!a_q[i][DW-1]) ext = ext + (a_q[i] << top.lvl);
      if (!b_q[i][DW-1]) ext = ext + (b_q[i] << top.lvl);
      sum = top.c[i] + ext;
      if (sum[DW-1]) hit = 1'b0;
    end
  end

  assign drain = ov_q && ready_out;

  always_comb begin
    int base;
    state_d = state_q;
    stk_d   = stk_q;
    sp_d    = sp_q;
    ov_d    = drain ? 1'b0 : ov_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oc_d    = oc_q;
    accept  = 1'b0;
    base    = int'(sp_q) - 1;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          accept   = 1'b1;
          stk_d[0] = '{lvl: LVL_TILE, x: xloc_in, y: yloc_in,
                       c: {edges_in[2][0], edges_in[1][0], edges_in[0][0]}};
          sp_d     = SPW'(1);
          state_d  = S_WALK;
        end
      end
      S_WALK: begin
        if (sp_q != '0) begin
          if (!hit) begin
            sp_d = sp_q - SPW'(1);
          end else if (top.lvl == LVL_BLK) begin
            if (!ov_q || drain) begin
              sp_d = sp_q - SPW'(1);
              ov_d = 1'b1;
              ox_d = top.x;
              oy_d = top.y;
              oc_d = top.c;
            end
          end else begin
            // Last pushed (x,y) pops first, giving Z order.
            sp_d = sp_q + SPW'(3);
            for (int k = 0; k < DEPTH; k++) begin
              if (k == base)          stk_d[k] = child(top, 1'b1, 1'b1, a_q, b_q);
              else if (k == base + 1) stk_d[k] = child(top, 1'b0, 1'b1, a_q, b_q);
              else if (k == base + 2) stk_d[k] = child(top, 1'b1, 1'b0, a_q, b_q);
              else if (k == base + 3) stk_d[k] = child(top, 1'b0, 1'b0, a_q, b_q);
            end
          end
        end
        if (sp_d == '0 && !ov_d) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stk_q   <= '0;
      sp_q    <= '0;
      ov_q    <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      oc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      stk_q   <= stk_d;
      sp_q    <= sp_d;
      ov_q    <= ov_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oc_q    <= oc_d;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          a_q[i] <= edges_in[i][2];
          b_q[i] <= edges_in[i][1];
        end
        pid_q <= pid_in;
      end
    end
  end

  assign ready_in  = (state_q == S_IDLE) && !reset;
  assign valid_out = ov_q;
  assign xloc_out  = ox_q;
  assign yloc_out  = oy_q;
  assign pid_out   = pid_q;
  assign busy      = (state_q == S_WALK) || ov_q;

  always_comb begin
    for (int i = 0; i < 3; i++) edges_out[i] = {a_q[i], b_q[i], oc_q[i]};
  end

`ifdef RASTER_WALKER_STATS_EN
  logic        st_tested, st_culled, st_emitted;
  logic [31:0] tested_q, culled_q, emitted_q;

  // A stalled block entry is re-tested next cycle, so only a consumed entry counts.
  assign st_tested  = (state_q == S_WALK) && (sp_q != '0) &&
                      !(hit && top.lvl == LVL_BLK && ov_q && !drain);
  assign st_culled  = st_tested && !hit;
  assign st_emitted = st_tested && hit && (top.lvl == LVL_BLK);

  always_ff @(posedge clk) begin
    if (reset) begin
      tested_q  <= '0;
      culled_q  <= '0;
      emitted_q <= '0;
    end else begin
      if (st_tested)  tested_q  <= tested_q + 32'd1;
      if (st_culled)  culled_q  <= culled_q + 32'd1;
      if (st_emitted) emitted_q <= emitted_q + 32'd1;
    end
  end

  assign perf_tested  = tested_q;
  assign perf_culled  = culled_q;
  assign perf_emitted = emitted_q;
`endif

endmodule

// File: tb/tb_raster_tile_walker.sv
// Directed bench for raster_tile_walker: full cover, full cull, half-plane, backpressure, reset mid-walk.
`ifndef RASTER_DIM_BITS
`define RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 24
`endif

module tb_raster_tile_walker;
  localparam int DIM = `RASTER_DIM_BITS;
  localparam int DW  = `RASTER_DATA_BITS;
  localparam int PW  = 8;

  typedef logic [2:0][2:0][DW-1:0] edges_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           valid_in = 1'b0;
  logic           ready_in;
  logic [DIM-1:0] xloc_in = DIM'(64);
  logic [DIM-1:0] yloc_in = DIM'(32);
  edges_t         edges_in = '0;
  logic [PW-1:0]  pid_in = '0;
  logic           valid_out;
  logic           ready_out = 1'b0;
  logic [DIM-1:0] xloc_out, yloc_out;
  edges_t         edges_out;
  logic [PW-1:0]  pid_out;
  logic           busy;
`ifdef RASTER_WALKER_STATS_EN
  logic [31:0]    perf_tested, perf_culled, perf_emitted;
`endif

  raster_tile_walker #(.TILE_LOGSIZE(5), .BLOCK_LOGSIZE(2), .PID_WIDTH(PW)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in),
    .xloc_in(xloc_in), .yloc_in(yloc_in), .edges_in(edges_in), .pid_in(pid_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .xloc_out(xloc_out), .yloc_out(yloc_out), .edges_out(edges_out), .pid_out(pid_out),
    .busy(busy)
`ifdef RASTER_WALKER_STATS_EN
    , .perf_tested(perf_tested), .perf_culled(perf_culled), .perf_emitted(perf_emitted)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_x[$];
  int exp_y[$];
  logic [DW-1:0] exp_c0[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic edges_t mk_edges(input int a0, input int b0, input int c0);
    edges_t e;
    e[0] = {DW'(a0), DW'(b0), DW'(c0)};
    e[1] = {DW'(0), DW'(0), DW'(1)};
    e[2] = {DW'(0), DW'(0), DW'(1)};
    return e;
  endfunction

  // Expected blocks in Z order over the 8x8 block grid; half keeps the x<80 columns.
  task automatic build_exp(input bit half);
    logic [5:0] m;
    int bx, by;
    exp_x.delete(); exp_y.delete(); exp_c0.delete();
    for (int i = 0; i < 64; i++) begin
      m  = 6'(i);
      bx = int'({m[4], m[2], m[0]});
      by = int'({m[5], m[3], m[1]});
      if (!half || bx < 4) begin
        exp_x.push_back(64 + 4 * bx);
        exp_y.push_back(32 + 4 * by);
        exp_c0.push_back(half ? DW'(15 - 4 * bx) : DW'(1));
      end
    end
  endtask

  task automatic run_prim(input edges_t e, input logic [PW-1:0] pid, input int rmode,
                          input int exp_first, input int exp_done, input int reset_after);
    int nexp, k, nblk, first, done, w;
    logic stalled;
    logic [DIM-1:0] hx, hy;
    logic [DW-1:0]  hc;
    nexp = exp_x.size();
    w = 0;
    while (!ready_in && w < 100) begin tick(); w++; end
    chk("ready_wait", ready_in, 1);
    edges_in = e; pid_in = pid; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; edges_in = '0; pid_in = '0;
    chk("ready_drop", ready_in, 0);
    chk("busy_walk", busy, 1);
    k = 1; nblk = 0; first = -1; done = -1; stalled = 1'b0;
    hx = '0; hy = '0; hc = '0;
    while (k < 600 && done < 0) begin
      ready_out = (rmode == 0) ? 1'b1 : (k % 3 == 0);
      if (stalled) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_x", xloc_out, hx);
        chk("hold_y", yloc_out, hy);
        chk("hold_c0", edges_out[0][0], hc);
      end
      if (valid_out && first < 0) first = k;
      if (ready_in) done = k;
      else if (valid_out && ready_out) begin
        nblk++;
        chk("blk_overrun", nblk <= nexp, 1);
        chk("blk_pid", pid_out, pid);
        if (exp_x.size() > 0) begin
          chk("blk_x", xloc_out, exp_x.pop_front());
          chk("blk_y", yloc_out, exp_y.pop_front());
          chk("blk_c0", edges_out[0][0], exp_c0.pop_front());
        end
        if (reset_after > 0 && nblk == reset_after) begin
          tick();
          reset = 1'b1;
          tick();
          chk("rst_valid", valid_out, 0);
          chk("rst_busy", busy, 0);
          chk("rst_ready", ready_in, 0);
          chk("rst_pid", pid_out, 0);
          reset = 1'b0;
          ready_out = 1'b0;
          tick(); tick();
          chk("rst_ready_back", ready_in, 1);
          chk("rst_no_emit", valid_out, 0);
          return;
        end
      end
      stalled = valid_out && !ready_out;
      hx = xloc_out; hy = yloc_out; hc = edges_out[0][0];
      tick();
      k++;
    end
    ready_out = 1'b0;
    chk("walk_done", done >= 0, 1);
    if (exp_first != -2) chk("first_valid_cycle", first, exp_first);
    if (exp_done != -2) chk("ready_back_cycle", done, exp_done);
    chk("blk_count", nblk, nexp);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    tick(); tick();
    chk("reset_ready", ready_in, 0);
    chk("reset_valid", valid_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_x", xloc_out, 0);
    chk("reset_pid", pid_out, 0);
    chk("reset_edges", edges_out, 0);
`ifdef RASTER_WALKER_STATS_EN
    chk("reset_perf_tested", perf_tested, 0);
`endif
    reset = 1'b0;
    tick();
    chk("ready_after_reset", ready_in, 1);

    build_exp(1'b0);
    run_prim(mk_edges(0, 0, 1), 8'h11, 0, 5, 87, 0);

    build_exp(1'b0);
    exp_x.delete(); exp_y.delete(); exp_c0.delete();
    run_prim(mk_edges(0, 0, -1), 8'h22, 0, -1, 2, 0);

`ifdef RASTER_WALKER_STATS_EN
    chk("perf_tested", perf_tested, 86);
    chk("perf_culled", perf_culled, 1);
    chk("perf_emitted", perf_emitted, 64);
`endif

    build_exp(1'b1);
    run_prim(mk_edges(-1, 0, 15), 8'h33, 0, 5, -2, 0);
    chk("a0_passthrough", edges_out[0][2], {DW{1'b1}});
    chk("b0_passthrough", edges_out[0][1], 0);

    build_exp(1'b0);
    run_prim(mk_edges(0, 0, 1), 8'h44, 1, 5, -2, 0);

    build_exp(1'b0);
    run_prim(mk_edges(0, 0, 1), 8'h55, 0, -2, -2, 10);

    build_exp(1'b0);
    run_prim(mk_edges(0, 0, 1), 8'hA6, 0, 5, 87, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_tile_walker.md
# raster_tile_walker

Hierarchical tile traversal controller for the raster unit. Accepts one primitive per tile as three edge equations plus tile origin. Recursively subdivides the tile into quadrants down to block granularity, using per-level edge extents to cull empty quadrants. Emits each overlapping block to the downstream block/quad evaluator through a valid/ready handshake.

## Interface
- `TILE_LOGSIZE`, 5: log2 of the tile edge length in pixels.
- `BLOCK_LOGSIZE`, 2: log2 of the emitted block edge length; must satisfy 0 < BLOCK_LOGSIZE <= TILE_LOGSIZE.
- `PID_WIDTH`, 8: primitive tag width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `valid_in` in 1: input primitive valid.
- `ready_in` out 1: walker idle and able to accept.
- `xloc_in`, `yloc_in` in `RASTER_DIM_BITS` each: tile origin.
- `edges_in` in [2:0][2:0][`RASTER_DATA_BITS`]: per edge i, {a, b, c}. c is the value at the tile origin, two's complement.
- `pid_in` in PID_WIDTH: primitive tag.
- `valid_out` out 1: block valid.
- `ready_out` in 1: downstream accepts block.
- `xloc_out`, `yloc_out` out `RASTER_DIM_BITS` each: block origin.
- `edges_out` out [2:0][2:0][`RASTER_DATA_BITS`]: a, b passed through; c re-evaluated at the block origin.
- `pid_out` out PID_WIDTH: tag of the current primitive.
- `busy` out 1: walk in progress, or output register occupied.

## Operation
- **States:**
  - IDLE: `ready_in`=1. On `valid_in`, latch a, b and pid. Push root entry {level=TILE_LOGSIZE, x, y, c[0..2]}. Go to WALK.
  - WALK: pop and test one stack entry per cycle. Stall only when the entry would emit and the output register is full and not draining this cycle.
  - When the stack is empty and the output register is empty or draining, go to IDLE.
- **Overlap test** at level L:
  - ext_i = (a_i>=0 ? a_i<<L : 0) + (b_i>=0 ? b_i<<L : 0).
  - The entry overlaps iff (c_i + ext_i) >= 0, signed, for all i. Equality counts as overlap.
- **Outcome of the test:**
  - Fail: the entry is discarded.
  - Pass with L==BLOCK_LOGSIZE: load the entry into the output register.
  - Pass with L>BLOCK_LOGSIZE: with h = 1<<(L-1), push four children at level L-1 in one cycle. Push order is (x+h,y+h), (x,y+h), (x+h,y), (x,y), so pops follow Z/Morton order.
  - Child c is c + (a<<(L-1))·dx + (b<<(L-1))·dy, where dx, dy ∈ {0,1}.
- **Stack:** register-based, depth 3·(TILE_LOGSIZE−BLOCK_LOGSIZE)+1. It never overflows by construction.
- **Arithmetic:** all in `RASTER_DATA_BITS`, wrapping. The producer guarantees no overflow for in-range tiles.

## Timing
- **Reset values:** state IDLE, stack empty, `valid_out`=0, `busy`=0, `ready_in`=0 while `reset` is high and 1 from the first cycle after. Data outputs are 0.
- **Reset mid-walk:** clears stack and output register in the same edge. No further blocks are emitted.
- **Acceptance:** a primitive is accepted on an edge where `valid_in`&&`ready_in`. Cycle n+k is the cycle k after that edge.
  - Root is tested in cycle 1.
  - The first block, if any, has `valid_out`=1 in cycle TILE_LOGSIZE−BLOCK_LOGSIZE+2.
- **Output register:** `valid_out` and all data outputs stay stable while `valid_out`&&!`ready_out`. An entry may be loaded on the same edge the previous one drains. Peak throughput is one test per cycle.
- **`ready_in`** deasserts the edge after acceptance. It reasserts the cycle after the last block handshake, or after the final cull.
- **Level equality:** when BLOCK_LOGSIZE==TILE_LOGSIZE, the walk is exactly one test cycle.

## Configuration
- `RASTER_WALKER_STATS_EN` defined: adds outputs `perf_tested`, `perf_culled`, `perf_emitted`.
  - Each is 32-bit, reset to 0, wrapping, cumulative across primitives.
  - Each increments once per tested, failed and handed-off entry, respectively.
- `RASTER_WALKER_STATS_EN` undefined: these ports and counters do not exist. Functional behaviour is identical.

## Test plan
Defaults, origin (64,32):
- **Full cover:** all edges a=b=0, c=1 -> 64 blocks in Morton order, from (64,32), (68,32), (64,36) to (92,60). 85 tests. `ready_out`=1 gives `ready_in` high by cycle 87.
- **Full cull:** edge0 c=−1, a=b=0 -> no `valid_out`; `ready_in` high in cycle 2.
- **Half-plane:** edge0 a=−1, b=0, c=15; other edges full cover -> exactly 32 blocks with x∈[64,76] and edges_out c0 = 15−(x−64). The x=80 quadrant is culled at level 4.
- **Backpressure:** full-cover case with `ready_out` high 1 of every 3 cycles -> same 64-block sequence; outputs stable while stalled; no drops or duplicates.
- **Reset mid-walk:** assert `reset` after the 10th block -> `valid_out`=0 the next cycle. A new primitive then walks cleanly with the correct pid.
- **Stats (macro on):** full cover then full cull -> `perf_tested`=86, `perf_culled`=1, `perf_emitted`=64.
